// File: rtl/elastic_operator.sv
// elastic_operator
//   Handshaked dataflow operator. Each operand channel requests a token from
//   its producer, captures it on acknowledge and holds it until every operand
//   is present. The operator then fires: the result is computed and written
//   into a small buffer shared by up to eight consumers (a fork). Each
//   consumer reads the buffer at its own pace through a private read pointer.
//   An entry is reused only after every consumer has read it.
//
// Parameters
//   data_width   token width in bits
//   op           reg | in | out | addi | subi | muli | add | sub | mul
//   immediate    constant operand for addi/subi/muli
//   input_size   operand channels (1..3)
//   output_size  consumers (1..8)
//   depth        result buffer entries (power of two, 1..64)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_l       per-operand request to the producer
//   ack_l       per-operand one-cycle acknowledge; din slice valid with it
//   din         operand i in bits [data_width*(i+1)-1 : data_width*i]
//   req_r       per-consumer request
//   ack_r       per-consumer one-cycle acknowledge
//   dout        per-consumer result slice, held until that consumer's next ack
//   fire_count  operations fired since reset (wraps)
module elastic_operator #(
    parameter int    data_width  = 32,
    parameter string op          = "reg",
    parameter int    immediate   = 0,
    parameter int    input_size  = 1,
    parameter int    output_size = 1,
    parameter int    depth       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [input_size-1:0]             req_l,
    input  logic [input_size-1:0]             ack_l,
    input  logic [data_width*input_size-1:0]  din,
    input  logic [output_size-1:0]            req_r,
    output logic [output_size-1:0]            ack_r,
    output logic [data_width*output_size-1:0] dout,
    output logic [31:0]                       fire_count
);
    // Pointers carry one bit above the index so full and empty differ.
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int PW = $clog2(depth) + 1;
    localparam logic [PW-1:0]         DEPTH_P = PW'(depth);
    localparam logic [data_width-1:0] IMM     = data_width'(immediate);
    localparam int OPC = (op == "addi") ? 1 :
                         (op == "subi") ? 2 :
                         (op == "muli") ? 3 :
                         (op == "add")  ? 4 :
                         (op == "sub")  ? 5 :
                         (op == "mul")  ? 6 : 0;

    logic [input_size-1:0]  req_l_q, req_l_d;
    logic [input_size-1:0]  has_q, has_d;
    logic [data_width-1:0]  opnd_q [input_size];
    logic [data_width-1:0]  opnd_d [input_size];
    logic [data_width-1:0]  mem_q [2**AW];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q [output_size];
    logic [PW-1:0]          rd_ptr_d [output_size];
    logic [output_size-1:0] ack_r_q, ack_r_d;
    logic [data_width-1:0]  dout_q [output_size];
    logic [data_width-1:0]  dout_d [output_size];
    logic [31:0]            fire_count_q, fire_count_d;
    logic                   full;
    logic                   fire;
    logic [data_width-1:0]  result;

    // With a single entry the index is always zero; the pointer bit alone
    // tells full from empty.
    function automatic logic [AW-1:0] idx(input logic [PW-1:0] p);
        if (depth == 1) return '0;
        else            return AW'(p);
    endfunction

    // The slowest consumer limits the buffer.
    always_comb begin
        full = 1'b0;
        for (int j = 0; j < output_size; j++) begin
            if ((wr_ptr_q - rd_ptr_q[j]) == DEPTH_P) full = 1'b1;
        end
    end

    assign fire = (&has_q) && !full;

    always_comb begin
        result = opnd_q[0];
        case (OPC)
            1: result = opnd_q[0] + IMM;
            2: result = opnd_q[0] - IMM;
            3: result = opnd_q[0] * IMM;
            4: for (int k = 1; k < input_size; k++) result = result + opnd_q[k];
            5: for (int k = 1; k < input_size; k++) result = result - opnd_q[k];
            6: for (int k = 1; k < input_size; k++) result = result * opnd_q[k];
            default: ;
        endcase
    end

    always_comb begin
        req_l_d      = req_l_q;
        has_d        = has_q;
        opnd_d       = opnd_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ack_r_d      = '0;
        dout_d       = dout_q;
        fire_count_d = fire_count_q;

        for (int i = 0; i < input_size; i++) begin
            if (ack_l[i] && !has_q[i]) begin
                opnd_d[i]  = din[data_width*i +: data_width];
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
            end else if (!has_q[i] && !req_l_q[i]) begin
                req_l_d[i] = 1'b1;
            end
        end

        // A fire needs every slot full, so it never coincides with a capture.
        if (fire) begin
            has_d        = '0;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            fire_count_d = fire_count_q + 32'd1;
        end

        // Readability uses the pre-edge write pointer: a result written on
        // this edge is served no earlier than the next one.
        for (int j = 0; j < output_size; j++) begin
            if (req_r[j] && !ack_r_q[j] && (rd_ptr_q[j] != wr_ptr_q)) begin
                ack_r_d[j]  = 1'b1;
                dout_d[j]   = mem_q[idx(rd_ptr_q[j])];
                rd_ptr_d[j] = rd_ptr_q[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q      <= '0;
            has_q        <= '0;
            wr_ptr_q     <= '0;
            ack_r_q      <= '0;
            fire_count_q <= '0;
            for (int i = 0; i < input_size; i++) opnd_q[i] <= '0;
            for (int j = 0; j < output_size; j++) begin
                rd_ptr_q[j] <= '0;
                dout_q[j]   <= '0;
            end
        end else begin
            req_l_q      <= req_l_d;
            has_q        <= has_d;
            opnd_q       <= opnd_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ack_r_q      <= ack_r_d;
            dout_q       <= dout_d;
            fire_count_q <= fire_count_d;
        end
    end

    // Buffer storage is not reset; entries are only reachable through the
    // pointers, which are.
    always_ff @(posedge clk) begin
        if (fire && !rst) mem_q[idx(wr_ptr_q)] <= result;
    end

    assign req_l      = req_l_q;
    assign ack_r      = ack_r_q;
    assign fire_count = fire_count_q;

    for (genvar g = 0; g < output_size; g++) begin : g_dout
        assign dout[data_width*g +: data_width] = dout_q[g];
    end

endmodule

// File: tb/tb_elastic_operator.sv
// tb_elastic_operator
//   Five operator instances share one clock and reset:
//     u_add  op=add, 2 operands, 32 bit
//     u_sub  op=sub, 3 operands, 8 bit
//     u_mul  op=mul, 3 operands, 16 bit
//     u_fork op=reg, 1 operand, 2 consumers, depth 4
//     u_imm  op=addi immediate=2, depth 1
//   Producers serve operands from per-channel queues; every expected result
//   is pushed to a per-consumer queue and popped when ack_r is observed.
module tb_elastic_operator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_l_a, ack_l_a;
    logic [63:0] din_a;
    logic [0:0]  req_r_a, ack_r_a;
    logic [31:0] dout_a, fc_a;

    logic [2:0]  req_l_s, ack_l_s;
    logic [23:0] din_s;
    logic [0:0]  req_r_s, ack_r_s;
    logic [7:0]  dout_s;
    logic [31:0] fc_s;

    logic [2:0]  req_l_m, ack_l_m;
    logic [47:0] din_m;
    logic [0:0]  req_r_m, ack_r_m;
    logic [15:0] dout_m;
    logic [31:0] fc_m;

    logic [0:0]  req_l_f, ack_l_f;
    logic [31:0] din_f;
    logic [1:0]  req_r_f, ack_r_f;
    logic [63:0] dout_f;
    logic [31:0] fc_f;

    logic [0:0]  req_l_i, ack_l_i;
    logic [31:0] din_i;
    logic [0:0]  req_r_i, ack_r_i;
    logic [31:0] dout_i, fc_i;

    elastic_operator #(.data_width(32), .op("add"), .input_size(2)) u_add (
        .clk(clk), .rst(rst), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a),
        .req_r(req_r_a), .ack_r(ack_r_a), .dout(dout_a), .fire_count(fc_a));
    elastic_operator #(.data_width(8), .op("sub"), .input_size(3)) u_sub (
        .clk(clk), .rst(rst), .req_l(req_l_s), .ack_l(ack_l_s), .din(din_s),
        .req_r(req_r_s), .ack_r(ack_r_s), .dout(dout_s), .fire_count(fc_s));
    elastic_operator #(.data_width(16), .op("mul"), .input_size(3)) u_mul (
        .clk(clk), .rst(rst), .req_l(req_l_m), .ack_l(ack_l_m), .din(din_m),
        .req_r(req_r_m), .ack_r(ack_r_m), .dout(dout_m), .fire_count(fc_m));
    elastic_operator #(.data_width(32), .op("reg"), .output_size(2), .depth(4)) u_fork (
        .clk(clk), .rst(rst), .req_l(req_l_f), .ack_l(ack_l_f), .din(din_f),
        .req_r(req_r_f), .ack_r(ack_r_f), .dout(dout_f), .fire_count(fc_f));
    elastic_operator #(.data_width(32), .op("addi"), .immediate(2), .depth(1)) u_imm (
        .clk(clk), .rst(rst), .req_l(req_l_i), .ack_l(ack_l_i), .din(din_i),
        .req_r(req_r_i), .ack_r(ack_r_i), .dout(dout_i), .fire_count(fc_i));

    logic [31:0] qa0[$], qa1[$], qs0[$], qs1[$], qs2[$], qm0[$], qm1[$], qm2[$], qf[$], qi[$];
    logic [31:0] exp_a[$], exp_s[$], exp_m[$], exp_f0[$], exp_f1[$], exp_i[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_ack_a = 0;
    int last_ackr_a = 0;
    int ackcnt_f = 0;
    logic pa = 1'b0, ps = 1'b0, pm = 1'b0, pi = 1'b0;
    logic [1:0] pf = 2'b00;
    bit inj_f = 1'b0;

    typedef struct {
        logic [31:0] a, b, c, e_add, e_sub, e_mul;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tok(input string nm, input bit had, input logic [31:0] act,
                       input logic [31:0] exp, input logic prev);
        if (!had) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected token %0h expected none", nm, act);
        end else begin
            check(nm, act, exp);
        end
        check({nm, " ack gap"}, 32'(prev), 32'd0);
    endtask

    task automatic monitor();
        logic [31:0] e;
        bit had;
        if (!rst) begin
            if (ack_r_a[0]) begin
                last_ackr_a = cyc;
                had = exp_a.size() > 0; e = '0;
                if (had) e = exp_a.pop_front();
                tok("add", had, dout_a, e, pa);
            end
            if (ack_r_s[0]) begin
                had = exp_s.size() > 0; e = '0;
                if (had) e = exp_s.pop_front();
                tok("sub", had, 32'(dout_s), e, ps);
            end
            if (ack_r_m[0]) begin
                had = exp_m.size() > 0; e = '0;
                if (had) e = exp_m.pop_front();
                tok("mul", had, 32'(dout_m), e, pm);
            end
            if (ack_r_f[0]) begin
                ackcnt_f++;
                had = exp_f0.size() > 0; e = '0;
                if (had) e = exp_f0.pop_front();
                tok("fork0", had, dout_f[31:0], e, pf[0]);
            end
            if (ack_r_f[1]) begin
                ackcnt_f++;
                had = exp_f1.size() > 0; e = '0;
                if (had) e = exp_f1.pop_front();
                tok("fork1", had, dout_f[63:32], e, pf[1]);
            end
            if (ack_r_i[0]) begin
                had = exp_i.size() > 0; e = '0;
                if (had) e = exp_i.pop_front();
                tok("addi", had, dout_i, e, pi);
            end
        end
        pa = ack_r_a[0]; ps = ack_r_s[0]; pm = ack_r_m[0]; pf = ack_r_f; pi = ack_r_i[0];
    endtask

    task automatic drive();
        ack_l_a = '0; ack_l_s = '0; ack_l_m = '0; ack_l_f = '0; ack_l_i = '0;
        if (req_l_a[0] && qa0.size() > 0) begin ack_l_a[0] = 1'b1; din_a[31:0]  = qa0.pop_front(); last_ack_a = cyc + 1; end
        if (req_l_a[1] && qa1.size() > 0) begin ack_l_a[1] = 1'b1; din_a[63:32] = qa1.pop_front(); last_ack_a = cyc + 1; end
        if (req_l_s[0] && qs0.size() > 0) begin ack_l_s[0] = 1'b1; din_s[7:0]   = 8'(qs0.pop_front()); end
        if (req_l_s[1] && qs1.size() > 0) begin ack_l_s[1] = 1'b1; din_s[15:8]  = 8'(qs1.pop_front()); end
        if (req_l_s[2] && qs2.size() > 0) begin ack_l_s[2] = 1'b1; din_s[23:16] = 8'(qs2.pop_front()); end
        if (req_l_m[0] && qm0.size() > 0) begin ack_l_m[0] = 1'b1; din_m[15:0]  = 16'(qm0.pop_front()); end
        if (req_l_m[1] && qm1.size() > 0) begin ack_l_m[1] = 1'b1; din_m[31:16] = 16'(qm1.pop_front()); end
        if (req_l_m[2] && qm2.size() > 0) begin ack_l_m[2] = 1'b1; din_m[47:32] = 16'(qm2.pop_front()); end
        if (inj_f) begin
            ack_l_f = 1'b1; din_f = 32'd99;
        end else if (req_l_f[0] && qf.size() > 0) begin
            ack_l_f = 1'b1; din_f = qf.pop_front();
        end
        if (req_l_i[0] && qi.size() > 0) begin ack_l_i = 1'b1; din_i = qi.pop_front(); end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        drive();
    endtask

    function automatic int pending();
        return exp_a.size() + exp_s.size() + exp_m.size() + exp_f0.size() + exp_f1.size() + exp_i.size();
    endfunction

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while (pending() != 0 && n < lim) begin
            tick();
            n++;
        end
        check({nm, " drained"}, 32'(pending()), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        int t0;
        req_r_a = 1'b1; req_r_s = 1'b1; req_r_m = 1'b1; req_r_i = 1'b1; req_r_f = 2'b00;
        ack_l_a = '0; ack_l_s = '0; ack_l_m = '0; ack_l_f = '0; ack_l_i = '0;
        din_a = '0; din_s = '0; din_m = '0; din_f = '0; din_i = '0;

        tbl[0] = '{32'd5,          32'd7,          32'd3,   32'd12,         32'hFB, 32'h0069};
        tbl[1] = '{32'd1,          32'd2,          32'd3,   32'd3,          32'hFC, 32'h0006};
        tbl[2] = '{32'hFFFF_FFFF,  32'd1,          32'd0,   32'd0,          32'hFE, 32'h0000};
        tbl[3] = '{32'h1234_5678,  32'h0000_0100,  32'd2,   32'h1234_5778,  32'h76, 32'hF000};
        tbl[4] = '{32'h8000_0003,  32'h8000_0005,  32'hFF,  32'd8,          32'hFF, 32'h0EF1};
        tbl[5] = '{32'd100,        32'd200,        32'd300, 32'h12C,        32'h70, 32'h8D80};

        rst = 1'b1;
        repeat (3) tick();
        check("rst req_l add", 32'(req_l_a), 32'd0);
        check("rst req_l fork", 32'(req_l_f), 32'd0);
        check("rst ack_r fork", 32'(ack_r_f), 32'd0);
        check("rst dout fork", dout_f[31:0], 32'd0);
        check("rst fire_count add", fc_a, 32'd0);
        rst = 1'b0;
        tick();
        check("first req_l add", 32'(req_l_a), 32'd3);
        check("first req_l sub", 32'(req_l_s), 32'd7);

        for (int r = 0; r < 6; r++) begin
            qa0.push_back(tbl[r].a); qa1.push_back(tbl[r].b);
            qs0.push_back(tbl[r].a); qs1.push_back(tbl[r].b); qs2.push_back(tbl[r].c);
            qm0.push_back(tbl[r].a); qm1.push_back(tbl[r].b); qm2.push_back(tbl[r].c);
            exp_a.push_back(tbl[r].e_add);
            exp_s.push_back(tbl[r].e_sub);
            exp_m.push_back(tbl[r].e_mul);
            wait_idle("vector", 30);
            check("add latency", 32'(last_ackr_a - last_ack_a), 32'd2);
            check("add fire_count", fc_a, 32'(r + 1));
            check("sub fire_count", fc_s, 32'(r + 1));
            check("mul fire_count", fc_m, 32'(r + 1));
        end

        // Consumer 1 idle: the buffer fills after four results and the fifth
        // operand is held in its slot; a stray ack on the full slot is ignored.
        req_r_f = 2'b01;
        for (int t = 1; t <= 6; t++) begin
            qf.push_back(32'(t)); exp_f0.push_back(32'(t)); exp_f1.push_back(32'(t));
        end
        repeat (40) tick();
        check("fork stalled fire_count", fc_f, 32'd4);
        check("fork c0 received", 32'(6 - exp_f0.size()), 32'd4);
        check("fork c1 received", 32'(6 - exp_f1.size()), 32'd0);
        check("fork req_l held low", 32'(req_l_f), 32'd0);
        inj_f = 1'b1;
        tick();
        inj_f = 1'b0;
        repeat (5) tick();
        check("fork fire_count after stray ack", fc_f, 32'd4);
        check("fork token 6 waiting", 32'(qf.size()), 32'd1);
        req_r_f = 2'b11;
        wait_idle("fork release", 100);
        check("fork fire_count final", fc_f, 32'd6);

        // Three results buffered, then reset discards them.
        req_r_f = 2'b00;
        qf.push_back(32'd7); qf.push_back(32'd8); qf.push_back(32'd9);
        n = 0;
        while (fc_f != 32'd9 && n < 40) begin
            tick();
            n++;
        end
        check("fork buffered before rst", fc_f, 32'd9);
        rst = 1'b1;
        repeat (2) tick();
        check("mid rst fire_count", fc_f, 32'd0);
        check("mid rst req_l", 32'(req_l_f), 32'd0);
        rst = 1'b0;
        req_r_f = 2'b11;
        tick();
        check("req_l after rst", 32'(req_l_f), 32'd1);
        base = ackcnt_f;
        repeat (10) tick();
        check("no ack_r after rst", 32'(ackcnt_f - base), 32'd0);
        check("fire_count after rst", fc_f, 32'd0);
        qf.push_back(32'd42); exp_f0.push_back(32'd42); exp_f1.push_back(32'd42);
        wait_idle("fork after rst", 30);
        check("fire_count new token", fc_f, 32'd1);

        // Single-entry buffer streaming at full rate.
        for (int v = 0; v < 5000; v++) begin
            qi.push_back(32'(v)); exp_i.push_back(32'(v + 2));
        end
        t0 = cyc;
        wait_idle("addi stream", 16000);
        check("addi fire_count", fc_i, 32'd5000);
        check("addi throughput", 32'((cyc - t0) <= 15010), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elastic_operator.md
ELASTIC_OPERATOR -- requirements
Module: elastic_operator

Interface
REQ-001 Parameter data_width, default 32: token width in bits.
REQ-002 Parameter op, default "reg": one of reg, in, out, addi, subi, muli, add, sub, mul.
REQ-003 Parameter immediate, default 0: constant operand for addi/subi/muli.
REQ-004 Parameter input_size, default 1, range 1..3: number of operand channels.
REQ-005 Parameter output_size, default 1, range 1..8: number of independent consumers (fork width).
REQ-006 Parameter depth, default 4, power of two, range 1..64: result buffer entries.
REQ-007 clk  input  1  the single clock; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 req_l  output  input_size  per-operand request to the upstream producer.
REQ-010 ack_l  input  input_size  per-operand one-cycle acknowledge; din slice valid in the same cycle.
REQ-011 din  input  data_width*input_size  operand i in bits [data_width*(i+1)-1 : data_width*i].
REQ-012 req_r  input  output_size  per-consumer request.
REQ-013 ack_r  output  output_size  per-consumer one-cycle acknowledge.
REQ-014 dout  output  data_width*output_size  per-consumer result, slice j valid while ack_r[j] is high and held until the next ack_r[j].
REQ-015 fire_count  output  32  number of operations fired since reset, wraps modulo 2^32.

Function
REQ-016 Operand slot i is empty or full (has[i]); when empty and req_l[i] low, req_l[i] goes high on the next edge and stays high until ack_l[i] is sampled.
REQ-017 On an edge with ack_l[i]=1 and has[i]=0: capture din slice i synchronously, set has[i], clear req_l[i]; ack_l[i] while has[i]=1 is ignored (no capture, no state change).
REQ-018 Fire: on an edge where all has bits are set and the buffer is not full, write the result into the buffer, clear all has bits, increment fire_count.
REQ-019 Result: reg/in/out pass operand 0; addi/subi/muli use operand 0 and immediate; add/sub/mul fold operand 0 op operand 1 (op operand 2); all results truncated to data_width (mod 2^data_width).
REQ-020 Buffer: one write pointer, one read pointer per consumer; entry freed only when every consumer has read it; full when any consumer has depth unread entries.
REQ-021 Consumer j served on an edge where req_r[j]=1, ack_r[j]=0, and j has an unread entry: ack_r[j]<=1, dout[j]<=oldest unread entry for j, advance read pointer j; otherwise ack_r[j]<=0.
REQ-022 ack_r[j] never high on two consecutive cycles; consumers progress independently (a stalled consumer blocks others only when buffer is full).
REQ-023 Latency: ack_l for last missing operand at edge t -> fire at edge t+1 -> earliest ack_r at edge t+2.
REQ-024 Full and empty evaluated from pre-edge state: a read in the same cycle does not permit a fire in that cycle; a fire in the same cycle does not make data readable that cycle.
REQ-025 Pointers wrap modulo depth with one extra bit to distinguish full from empty; depth=1 is supported.
REQ-026 Back-to-back: with all operands supplied every cycle and consumers always requesting, sustained throughput is one fire every 3 cycles per input handshake, never lower.

Reset
REQ-027 While rst=1: req_l=0, has=0, ack_r=0, dout=0, fire_count=0, all pointers 0, buffer contents undefined and unreadable.
REQ-028 rst asserted mid-operation discards captured operands and buffered results; first req_l rises on the first edge after rst deasserts.

Verification
REQ-029 op=add, input_size=2, din={5,7}, single consumer -> dout=12, ack_r one cycle, fire_count=1, ack_r exactly 2 cycles after last ack_l.
REQ-030 op=sub, input_size=3, data_width=8, operands 1,2,3 -> dout=8'hFC.
REQ-031 output_size=2, depth=4, consumer 1 held idle, 6 tokens offered -> consumer 0 receives 4, fire_count stops at 4, req_l stays low; releasing consumer 1 yields tokens 1..6 in order at both consumers.
REQ-032 ack_l asserted while has[0]=1 with din=99 -> value not captured, output equals earlier token.
REQ-033 rst pulsed with 3 buffered results -> no ack_r after reset until new operands arrive, fire_count=0.
REQ-034 depth=1, op=addi immediate=2, producer counting 0..4999, consumer always requesting -> outputs 2..5001 in order, no loss or duplication.
